mem_access_unit: RTL and testbench

CPU-side load/store controller that drives the byte-lane data memory port. It accepts one load or store request at a time: byte, halfword or word, signed or unsigned. It converts the byte address into a word address plus a 4-bit lane select, replicates store data into lanes, and issues single-cycle str/ld strobes. For loads it captures the memory's registered read data one cycle later, then extracts, shifts and sign- or zero-extends it into a 32-bit result.

---
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : CPU-side load/store controller for a byte-lane data memory.
//            Accepts one byte/half/word load or store at a time, drives a
//            word address, lane select and lane-replicated store data, issues
//            single-cycle str/ld strobes, and for loads sign/zero-extends the
//            selected lanes of the memory's registered read data.
// Ports    : clk, clr (async active-low)
//            req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/
//            req_wdata     - request side
//            resp_valid/resp_rdata/resp_misalign - one-cycle response
//            mem_addr/mem_datain/mem_sel/mem_str/mem_ld/mem_dataout
//                          - data memory port
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_datain,
  output logic [3:0]        mem_sel,
  output logic              mem_str,
  output logic              mem_ld,
  input  logic [31:0]       mem_dataout
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ST   = 3'd1;
  localparam logic [2:0] LD   = 3'd2;
  localparam logic [2:0] CAP  = 3'd3;
  localparam logic [2:0] RESP = 3'd4;

  logic [2:0]  r_state;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;

  logic        w_misalign;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;

  // Address bits above the memory's word range wrap around.
  logic w_unused_addr;
  assign w_unused_addr = &{1'b0, req_addr[31:ADDR_W+2]};

  // Strobes and handshakes decode straight from state so an asynchronous
  // reset drops them in the same instant.
  assign req_ready  = (r_state == IDLE);
  assign mem_str    = (r_state == ST);
  assign mem_ld     = (r_state == LD);
  assign resp_valid = (r_state == RESP);

  // Size 3 behaves as a word everywhere, hence the size[1] tests.
  assign w_misalign = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));

  always_comb begin
    w_sel   = 4'b1111;
    w_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        w_sel   = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_sel   = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane extraction from the read data returned by the memory.
  always_comb begin
    w_byte = mem_dataout[7:0];
    case (r_off)
      2'd1:    w_byte = mem_dataout[15:8];
      2'd2:    w_byte = mem_dataout[23:16];
      2'd3:    w_byte = mem_dataout[31:24];
      default: ;
    endcase
    w_half = r_off[1] ? mem_dataout[31:16] : mem_dataout[15:0];
    w_ext  = mem_dataout;
    case (r_size)
      2'd0:    w_ext = r_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'd1:    w_ext = r_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= IDLE;
      r_size        <= 2'd0;
      r_unsigned    <= 1'b0;
      r_off         <= 2'd0;
      mem_addr      <= '0;
      mem_sel       <= 4'd0;
      mem_datain    <= 32'd0;
      resp_rdata    <= 32'd0;
      resp_misalign <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            mem_addr      <= req_addr[ADDR_W+1:2];
            mem_sel       <= w_sel;
            mem_datain    <= w_wdata;
            r_size        <= req_size;
            r_unsigned    <= req_unsigned;
            r_off         <= req_addr[1:0];
            resp_rdata    <= 32'd0;
            resp_misalign <= w_misalign;
            if (w_misalign)  r_state <= RESP;
            else if (req_we) r_state <= ST;
            else             r_state <= LD;
          end
        end
        ST:  r_state <= RESP;
        LD:  r_state <= CAP;
        CAP: begin
          resp_rdata <= w_ext;
          r_state    <= RESP;
        end
        RESP: begin
          resp_misalign <= 1'b0;
          r_state       <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench for mem_access_unit with a
//            byte-lane memory model (registered read, masked write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misalign;
  logic [11:0] mem_addr;
  logic [31:0] mem_datain;
  logic [3:0]  mem_sel;
  logic        mem_str;
  logic        mem_ld;
  logic [31:0] mem_dataout = 32'd0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: registered read on ld, byte-masked write on str.
  always @(posedge clk) begin
    if (mem_ld)
      mem_dataout <= mem[mem_addr] & {{8{mem_sel[3]}}, {8{mem_sel[2]}},
                                      {8{mem_sel[1]}}, {8{mem_sel[0]}}};
    if (mem_str) begin
      if (mem_sel[0]) mem[mem_addr][7:0]   <= mem_datain[7:0];
      if (mem_sel[1]) mem[mem_addr][15:8]  <= mem_datain[15:8];
      if (mem_sel[2]) mem[mem_addr][23:16] <= mem_datain[23:16];
      if (mem_sel[3]) mem[mem_addr][31:24] <= mem_datain[31:24];
    end
  end

  mem_access_unit #(.ADDR_W(12)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_sel(mem_sel),
    .mem_str(mem_str), .mem_ld(mem_ld), .mem_dataout(mem_dataout)
  );

  // Drives one request from idle and records what the DUT does over the next
  // six cycles. rcyc = cycle after acceptance in which resp_valid appeared
  // (0 if never).
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int rcyc, output logic [31:0] rdata,
                       output logic mis, output int nstr, output int nld,
                       output logic [3:0] sel1, output logic [31:0] din1,
                       output logic [11:0] addr1);
    rcyc = 0; rdata = 32'hFFFF_FFFF; mis = 1'b0; nstr = 0; nld = 0;
    sel1 = 4'd0; din1 = 32'd0; addr1 = 12'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        sel1 = mem_sel; din1 = mem_datain; addr1 = mem_addr;
      end
      if (mem_str) nstr++;
      if (mem_ld)  nld++;
      if (resp_valid && rcyc == 0) begin
        rcyc = k; rdata = resp_rdata; mis = resp_misalign;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    #12;
    checks++;
    if ({mem_str, mem_ld, resp_valid, resp_misalign} !== 4'b0000 ||
        mem_sel !== 4'd0 || mem_addr !== 12'd0 || mem_datain !== 32'd0 ||
        resp_rdata !== 32'd0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: str=%b ld=%b rv=%b mis=%b sel=%h addr=%h din=%h rdata=%h rdy=%b, required all 0 and rdy=1",
               mem_str, mem_ld, resp_valid, resp_misalign, mem_sel, mem_addr,
               mem_datain, resp_rdata, req_ready);
    end
    @(negedge clk);
    clr = 1'b1;
  endtask

  task automatic test_store_word_byte();
    int rc, ns, nl; logic [31:0] rd, din; logic mi; logic [3:0] sel; logic [11:0] ad;
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (ad !== 12'd4 || sel !== 4'b1111 || din !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_port: addr=%h sel=%b din=%h, required 004 1111 deadbeef", ad, sel, din);
    end
    checks++;
    if (ns !== 1 || nl !== 0) begin
      errors++;
      $display("FAIL sw_strobes: str=%0d ld=%0d, required 1 0", ns, nl);
    end
    checks++;
    if (rc !== 2 || rd !== 32'd0 || mi !== 1'b0) begin
      errors++;
      $display("FAIL sw_resp: cycle=%0d rdata=%h mis=%b, required 2 0 0", rc, rd, mi);
    end
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (sel !== 4'b1000 || din !== 32'hA5A5A5A5 || ns !== 1 || rc !== 2) begin
      errors++;
      $display("FAIL sb_port: sel=%b din=%h str=%0d cycle=%0d, required 1000 a5a5a5a5 1 2",
               sel, din, ns, rc);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (rd !== 32'hA5ADBEEF || rc !== 3 || nl !== 1 || ns !== 0) begin
      errors++;
      $display("FAIL lw_after_sb: rdata=%h cycle=%0d ld=%0d str=%0d, required a5adbeef 3 1 0",
               rd, rc, nl, ns);
    end
  endtask

  task automatic test_loads();
    int rc, ns, nl; logic [31:0] rd, din; logic mi; logic [3:0] sel; logic [11:0] ad;
    logic [1:0]  sz  [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic        un  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ar  [6] = '{32'h21, 32'h22, 32'h23, 32'h22, 32'h22, 32'h20};
    logic [31:0] exp [6] = '{32'h0000007F, 32'hFFFFFFF1, 32'h00000080,
                             32'hFFFF80F1, 32'h000080F1, 32'h80F17F01};
    logic [3:0]  es  [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b1100, 4'b1111};
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F17F01, rc, rd, mi, ns, nl, sel, din, ad);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, sz[i], un[i], ar[i], 32'd0, rc, rd, mi, ns, nl, sel, din, ad);
      checks++;
      if (rd !== exp[i] || rc !== 3 || sel !== es[i] || nl !== 1 || mi !== 1'b0) begin
        errors++;
        $display("FAIL load_%0d: rdata=%h cycle=%0d sel=%b ld=%0d mis=%b, required %h 3 %b 1 0",
                 i, rd, rc, sel, nl, mi, exp[i], es[i]);
      end
    end
  endtask

  task automatic test_misalign();
    int rc, ns, nl; logic [31:0] rd, din; logic mi; logic [3:0] sel; logic [11:0] ad;
    issue(1'b0, 2'd2, 1'b0, 32'h22, 32'd0, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (rc !== 1 || mi !== 1'b1 || rd !== 32'd0 || ns !== 0 || nl !== 0) begin
      errors++;
      $display("FAIL mis_lw: cycle=%0d mis=%b rdata=%h str=%0d ld=%0d, required 1 1 0 0 0",
               rc, mi, rd, ns, nl);
    end
    issue(1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344, rc, rd, mi, ns, nl, sel, din, ad);
    issue(1'b1, 2'd1, 1'b0, 32'h05, 32'h0000FFFF, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (rc !== 1 || mi !== 1'b1 || ns !== 0 || nl !== 0) begin
      errors++;
      $display("FAIL mis_sh: cycle=%0d mis=%b str=%0d ld=%0d, required 1 1 0 0", rc, mi, ns, nl);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (rd !== 32'h11223344 || mi !== 1'b0) begin
      errors++;
      $display("FAIL mis_sh_mem: rdata=%h mis=%b, required 11223344 0", rd, mi);
    end
  endtask

  task automatic test_back_to_back();
    logic        we  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  sz  [4] = '{2'd2, 2'd2, 2'd0, 2'd2};
    logic [31:0] ar  [4] = '{32'h40, 32'h40, 32'h41, 32'h40};
    logic [31:0] wd  [4] = '{32'h12345678, 32'd0, 32'h00000099, 32'd0};
    int acc [4];
    logic [31:0] resps [8];
    int nacc = 0, nresp = 0, nstr = 0, nld = 0, busy_err = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((mem_str || mem_ld || resp_valid) && req_ready) busy_err++;
      if (mem_str) nstr++;
      if (mem_ld)  nld++;
      if (resp_valid && nresp < 8) begin resps[nresp] = resp_rdata; nresp++; end
      if (req_ready) begin
        if (nacc < 4) begin
          req_valid = 1'b1; req_we = we[nacc]; req_size = sz[nacc];
          req_unsigned = 1'b0; req_addr = ar[nacc]; req_wdata = wd[nacc];
          acc[nacc] = cyc + 1;
          nacc++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nacc !== 4 || nresp !== 4) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d responses=%0d, required 4 4", nacc, nresp);
    end
    checks++;
    if (nstr !== 2 || nld !== 2 || busy_err !== 0) begin
      errors++;
      $display("FAIL b2b_strobes: str=%0d ld=%0d ready_while_busy=%0d, required 2 2 0",
               nstr, nld, busy_err);
    end
    if (nacc == 4) begin
      checks++;
      if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 4 || acc[3] - acc[2] !== 3) begin
        errors++;
        $display("FAIL b2b_interval: %0d %0d %0d, required 3 4 3",
                 acc[1] - acc[0], acc[2] - acc[1], acc[3] - acc[2]);
      end
    end
    if (nresp == 4) begin
      checks++;
      if (resps[1] !== 32'h12345678 || resps[3] !== 32'h12349978 ||
          resps[0] !== 32'd0 || resps[2] !== 32'd0) begin
        errors++;
        $display("FAIL b2b_data: %h %h %h %h, required 0 12345678 0 12349978",
                 resps[0], resps[1], resps[2], resps[3]);
      end
    end
  endtask

  task automatic test_reset_mid_store();
    int rc, ns, nl, rv = 0; logic [31:0] rd, din; logic mi; logic [3:0] sel; logic [11:0] ad;
    issue(1'b1, 2'd2, 1'b0, 32'h80, 32'hAAAAAAAA, rc, rd, mi, ns, nl, sel, din, ad);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h80;
    req_wdata = 32'h55555555;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    checks++;
    if (mem_str !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: str=%b, required 1", mem_str);
    end
    clr = 1'b0;
    #1;
    checks++;
    if (mem_str !== 1'b0 || resp_valid !== 1'b0 || mem_sel !== 4'd0) begin
      errors++;
      $display("FAIL abort_drop: str=%b rv=%b sel=%b, required 0 0 0", mem_str, resp_valid, mem_sel);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    checks++;
    if (rv !== 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_after: resp_pulses=%0d ready=%b, required 0 1", rv, req_ready);
    end
    issue(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, rc, rd, mi, ns, nl, sel, din, ad);
    checks++;
    if (rd !== 32'hAAAAAAAA) begin
      errors++;
      $display("FAIL abort_mem: rdata=%h, required aaaaaaaa", rd);
    end
  endtask

  initial begin
    test_reset();
    test_store_word_byte();
    test_loads();
    test_misalign();
    test_back_to_back();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
